// File: rtl/priority_seg_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : priority_seg_control_pkg
// Description : Shared glyph constants and types for the priority display.
// Revision    : 1.0 - initial release
// ============================================================================
package priority_seg_control_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment order {a,b,c,d,e,f,g,dp}; dp is never lit.
    localparam logic [7:0] GLYPH_0     = 8'hFC;
    localparam logic [7:0] GLYPH_1     = 8'h60;
    localparam logic [7:0] GLYPH_2     = 8'hDA;
    localparam logic [7:0] GLYPH_3     = 8'hF2;
    localparam logic [7:0] GLYPH_DASH  = 8'h02;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    typedef logic [2:0] digit_idx_t;

    typedef enum logic [2:0] {
        CODE_0     = 3'd0,
        CODE_1     = 3'd1,
        CODE_2     = 3'd2,
        CODE_3     = 3'd3,
        CODE_DASH  = 3'd4,
        CODE_BLANK = 3'd5
    } glyph_code_t;

endpackage : priority_seg_control_pkg
`default_nettype wire

// File: rtl/priority_seg_control_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_rom
// Description : Combinational map from glyph code to 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_rom
    import priority_seg_control_pkg::*;
(
    input  glyph_code_t i_code,
    output logic [7:0]  o_seg
);

    always_comb begin
        o_seg = GLYPH_BLANK;
        case (i_code)
            CODE_0:    o_seg = GLYPH_0;
            CODE_1:    o_seg = GLYPH_1;
            CODE_2:    o_seg = GLYPH_2;
            CODE_3:    o_seg = GLYPH_3;
            CODE_DASH: o_seg = GLYPH_DASH;
            default:   o_seg = GLYPH_BLANK;
        endcase
    end

endmodule : seg7_glyph_rom
`default_nettype wire

// File: rtl/priority_seg_control.sv
`default_nettype none
// ============================================================================
// Module      : priority_seg_control
// Description : Priority-encodes four switches onto an 8-digit scanned display.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_seg_control
    import priority_seg_control_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       N_Reset,
    input  logic       I3,
    input  logic       I2,
    input  logic       I1,
    input  logic       I0,
    output logic [7:0] SEG_COM,
    output logic [7:0] SEG_DATA
);

    localparam int             c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);

    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [c_DIV_W-1:0] r_div;
    digit_idx_t         r_ptr;
    logic [7:0]         r_seg_com;
    logic [7:0]         r_seg_data;

    logic               w_valid;
    logic [1:0]         w_idx;
    logic               w_div_tc;
    glyph_code_t        w_code;
    logic [7:0]         w_glyph;
    logic [7:0]         w_com;

    always_comb begin
        w_valid = 1'b1;
        w_idx   = 2'd0;
        if (r_sync2[3])      w_idx = 2'd3;
        else if (r_sync2[2]) w_idx = 2'd2;
        else if (r_sync2[1]) w_idx = 2'd1;
        else if (r_sync2[0]) w_idx = 2'd0;
        else                 w_valid = 1'b0;
    end

    // Upper digits echo raw bits, digit 0 carries the encoded index.
    always_comb begin
        w_code = CODE_BLANK;
        case (r_ptr)
            3'd7:    w_code = r_sync2[3] ? CODE_1 : CODE_0;
            3'd6:    w_code = r_sync2[2] ? CODE_1 : CODE_0;
            3'd5:    w_code = r_sync2[1] ? CODE_1 : CODE_0;
            3'd4:    w_code = r_sync2[0] ? CODE_1 : CODE_0;
            3'd0:    w_code = w_valid ? glyph_code_t'({1'b0, w_idx}) : CODE_DASH;
            default: w_code = CODE_BLANK;
        endcase
    end

    seg7_glyph_rom u_rom (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    assign w_div_tc = (r_div == c_DIV_LAST);
    assign w_com    = ~(NUM_DIGITS'(1) << r_ptr);

    always_ff @(posedge clk or negedge N_Reset) begin
        if (!N_Reset) begin
            r_sync1    <= 4'd0;
            r_sync2    <= 4'd0;
            r_div      <= '0;
            r_ptr      <= '0;
            r_seg_com  <= 8'hFF;
            r_seg_data <= 8'h00;
        end else begin
            r_sync1    <= {I3, I2, I1, I0};
            r_sync2    <= r_sync1;
            r_div      <= w_div_tc ? '0 : r_div + 1'b1;
            if (w_div_tc)
                r_ptr  <= r_ptr + 3'd1;
            r_seg_com  <= w_com;
            r_seg_data <= w_glyph;
        end
    end

    assign SEG_COM  = r_seg_com;
    assign SEG_DATA = r_seg_data;

endmodule : priority_seg_control
`default_nettype wire

// File: tb/tb_priority_seg_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_seg_control
// Description : Scoreboard bench for priority_seg_control (SCAN_DIV 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_seg_control;

    localparam int SCAN_DIV = 4;

    typedef struct {
        logic [7:0] com;
        logic [7:0] data;
        logic [7:0] com1;
        logic [7:0] data1;
    } exp_t;

    logic       clk = 1'b0;
    logic       N_Reset = 1'b0;
    logic       I3 = 1'b0, I2 = 1'b0, I1 = 1'b0, I0 = 1'b0;
    logic [7:0] SEG_COM, SEG_DATA, SEG_COM1, SEG_DATA1;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [3:0] hist[$];
    int         n_edges = 0;

    priority_seg_control #(.SCAN_DIV(SCAN_DIV)) u_dut (
        .clk(clk), .N_Reset(N_Reset), .I3(I3), .I2(I2), .I1(I1), .I0(I0),
        .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA)
    );

    priority_seg_control #(.SCAN_DIV(1)) u_dut1 (
        .clk(clk), .N_Reset(N_Reset), .I3(I3), .I2(I2), .I1(I1), .I0(I0),
        .SEG_COM(SEG_COM1), .SEG_DATA(SEG_DATA1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_glyph(input int d, input logic [3:0] v);
        logic [7:0] gl[4];
        gl = '{8'hFC, 8'h60, 8'hDA, 8'hF2};
        if (d >= 4) return v[d-4] ? 8'h60 : 8'hFC;
        if (d > 0)  return 8'h00;
        for (int b = 3; b >= 0; b--)
            if (v[b]) return gl[b];
        return 8'h02;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the n-th edge after release shows digit (n-1)/div mod 8,
    // built from the switch value present two edges earlier.
    always @(posedge clk or negedge N_Reset) begin
        if (!N_Reset) begin
            n_edges = 0;
            hist.delete();
            sb.delete();
        end else begin
            exp_t       e;
            logic [3:0] v;
            int         d, d1;
            n_edges++;
            hist.push_back({I3, I2, I1, I0});
            v  = (hist.size() >= 3) ? hist[hist.size()-3] : 4'd0;
            d  = ((n_edges - 1) / SCAN_DIV) % 8;
            d1 = (n_edges - 1) % 8;
            e.com   = ~(8'd1 << d);
            e.data  = ref_glyph(d, v);
            e.com1  = ~(8'd1 << d1);
            e.data1 = ref_glyph(d1, v);
            sb.push_back(e);
        end
    end

    always @(posedge clk) begin
        #1;
        if (N_Reset && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("seg_com",   SEG_COM,   e.com);
            check("seg_data",  SEG_DATA,  e.data);
            check("seg_com_div1",  SEG_COM1,  e.com1);
            check("seg_data_div1", SEG_DATA1, e.data1);
            check("onehot_div1", 8'($countones(~SEG_COM1)), 8'd1);
        end
    end

    task automatic set_in(input logic [3:0] v);
        {I3, I2, I1, I0} = v;
    endtask

    initial begin
        logic [3:0] pats[6];
        bit         found;
        pats = '{4'b1000, 4'b0100, 4'b1110, 4'b0011, 4'b0001, 4'b0000};

        repeat (3) @(negedge clk);
        check("reset_com",  SEG_COM,  8'hFF);
        check("reset_data", SEG_DATA, 8'h00);
        check("reset_com_div1", SEG_COM1, 8'hFF);

        set_in(pats[0]);
        N_Reset = 1'b1;
        @(posedge clk); #2;
        check("first_com", SEG_COM, 8'hFE);

        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            set_in(pats[p]);
            repeat (8 * SCAN_DIV + 4) @(negedge clk);
        end

        for (int r = 0; r < 25; r++) begin
            set_in(4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (SEG_COM == 8'hDF) found = 1'b1;
        end
        if (!found) begin
            errors++;
            $display("FAIL midscan_wait: digit 5 never selected within budget");
        end
        N_Reset = 1'b0;
        #1;
        check("midscan_reset_com",  SEG_COM,  8'hFF);
        check("midscan_reset_data", SEG_DATA, 8'h00);
        repeat (2) @(negedge clk);
        set_in(4'b0101);
        N_Reset = 1'b1;
        @(posedge clk); #2;
        check("restart_com", SEG_COM, 8'hFE);
        repeat (8 * SCAN_DIV * 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_priority_seg_control
`default_nettype wire
